cache_evict_fill: RTL and testbench
===================================

// Module: cache_evict_fill
// PURPOSE
//  Consumer of the replacement policy's VictimWay. On a cache miss it evicts the victim line and refills it.
//  - Dirty victim: writes the victim line back to the bus first.
//  - Then fetches the missed line beat by beat and installs it in the chosen way.
//  - Drives SetValid/ClearValid/LRUWriteEn back to the tag array and the replacement policy.
//  Sits between the cache controller FSM and the bus adapter.
// PARAMETERS
//  NUMWAYS   4    ways per set; VictimWay/FillWay width
//  SETLEN    7    set-index bits
//  OFFSETLEN 5    line-offset bits (LINELEN/8 bytes per line)
//  LINELEN   256  line width in bits
//  AHBW      64   bus data width; BEATS = LINELEN/AHBW, BOFF = log2(AHBW/8)
//  PA_BITS   32   physical address width; TAGLEN = PA_BITS-SETLEN-OFFSETLEN
// PORTS
//  clk         in   1         clock
//  reset       in   1         async active-high reset
//  MissReq     in   1         miss request, sampled only in IDLE
//  MissAdr     in   PA_BITS   missing byte address
//  VictimWay   in   NUMWAYS   one-hot victim from replacement policy
//  VictimDirty in   1         victim line dirty
//  VictimTag   in   TAGLEN    victim line tag
//  LineRead    in   LINELEN   victim line data, valid in the MissReq accept cycle
//  BusAck      in   1         current beat completes this cycle
//  BusRData    in   AHBW      read beat data, valid with BusAck on reads
//  BusReq      out  1         beat request
//  BusWrite    out  1         1 = writeback beat, 0 = fetch beat
//  BusAdr      out  PA_BITS   beat byte address
//  BusWData    out  AHBW      writeback beat data
//  FillData    out  LINELEN   assembled line, valid with SetValid
//  FillWay     out  NUMWAYS   latched victim way
//  ClearValid  out  1         invalidate victim way (1-cycle pulse)
//  SetValid    out  1         write FillData and set valid (1-cycle pulse)
//  LRUWriteEn  out  1         update replacement state (pulses with SetValid)
//  MissDone    out  1         miss complete (pulses with SetValid)
//  Busy        out  1         state != IDLE
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE, beat counter=0, all outputs 0, buffers 0.
//  States: IDLE, WB, FETCH, FILL.
//  IDLE, MissReq=1 (accept cycle):
//  - Latch MissAdr, VictimWay, VictimTag; snapshot LineRead into the writeback buffer.
//  - Pulse ClearValid (FillWay already = VictimWay combinationally).
//  - Next state WB if VictimDirty, else FETCH. Beat counter = 0.
//  WB:
//  - BusReq=1, BusWrite=1, BusAdr={VictimTag, set, 0} + beat*AHBW/8.
//  - BusWData = writeback buffer slice [beat*AHBW +: AHBW].
//  FETCH:
//  - BusReq=1, BusWrite=0, BusAdr={MissAdr line base} + beat*AHBW/8.
//  - On BusAck, capture BusRData into FillData[beat*AHBW +: AHBW].
//  Beat handling (WB and FETCH):
//  - BusAck=0 holds BusReq/BusAdr/BusWData stable; the counter does not advance.
//  - BusAck=1 advances the counter modulo BEATS.
//  - The BEATS-th ack moves WB->FETCH or FETCH->FILL and resets the count.
//  FILL: one cycle; SetValid=LRUWriteEn=MissDone=1, then IDLE.
//  Busy=1 from the cycle after accept through the FILL cycle.
//  Latency:
//  - Clean miss, zero wait: accept at cycle 0, fetch beats 1..BEATS, FILL at BEATS+1.
//  - Dirty miss adds BEATS cycles.
//  Boundaries:
//  - MissReq outside IDLE is ignored; not queued.
//  - BusAck outside WB/FETCH is ignored.
//  - VictimWay must be one-hot; zero or multi-hot is flagged by a simulation assertion and is not functional.
//  - Reset mid-operation abandons the transfer; no SetValid is issued.
//    The victim way stays invalid (ClearValid was already sent).
// CONFIGURATION
//  CACHE_CRITICAL_WORD_FIRST_EN:
//  - Defined: FETCH starts at beat MissAdr[OFFSETLEN-1:BOFF] and wraps modulo BEATS.
//    Each beat is still stored at its true line position.
//  - Undefined: FETCH always starts at beat 0.
//  - Either way: WB always starts at beat 0, and FILL follows exactly BEATS acks.
// TESTING
//  T1 Clean miss (BEATS=4; BusAck=1 every cycle), MissAdr=0x00001040, VictimWay=4'b0100, VictimDirty=0
//     -> reads at 0x1040/48/50/58; SetValid+MissDone at cycle 5; FillWay=0100; beat0 data in FillData[63:0].
//  T2 Dirty miss (BEATS=4), VictimTag=0x12345, MissAdr=0x1040
//     -> 4 writes at 0x12345040..58 carrying LineRead[63:0]..[255:192], then T1 read sequence; SetValid at cycle 9.
//  T3 T1 with BusAck low 3 cycles before each beat
//     -> BusAdr stable while waiting; no double capture; SetValid at cycle 17.
//  T4 MissReq pulsed during FETCH with a different address
//     -> ignored; only the original line is filled; one MissDone.
//  T5 Reset asserted during the 2nd WB beat
//     -> all outputs 0 immediately (async); Busy=0; no SetValid; next MissReq accepted normally.
//  T6 CACHE_CRITICAL_WORD_FIRST_EN defined, MissAdr=0x1050
//     -> reads at 0x1050,0x1058,0x1040,0x1048; FillData identical to the in-order fill.

Source files
------------

// File: rtl/cache_evict_fill_if.sv
// Bus-side beat channel between cache_evict_fill (master) and the bus adapter (slave).
// BusReq is the beat's valid; BusAck is its ready. A beat completes on the clock edge where both are
// high. While BusReq is high and BusAck low, the master holds BusWrite/BusAdr/BusWData stable.
// BusRData is only meaningful on read beats, in the cycle BusAck is high.
interface cache_evict_fill_if #(
  parameter int PA_BITS = 32,
  parameter int AHBW    = 64
);
  logic               BusReq;
  logic               BusWrite;
  logic [PA_BITS-1:0] BusAdr;
  logic [AHBW-1:0]    BusWData;
  logic               BusAck;
  logic [AHBW-1:0]    BusRData;

  modport master (output BusReq, BusWrite, BusAdr, BusWData, input BusAck, BusRData);
  modport slave  (input BusReq, BusWrite, BusAdr, BusWData, output BusAck, BusRData);
endinterface

// File: rtl/cache_evict_fill.sv
// Miss handler: writes back a dirty victim line, fetches the missed line beat by beat and installs it.
// Optional CACHE_CRITICAL_WORD_FIRST_EN starts the fetch at the missed beat and wraps around the line.
module cache_evict_fill #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 7,
  parameter int OFFSETLEN = 5,
  parameter int LINELEN   = 256,
  parameter int AHBW      = 64,
  parameter int PA_BITS   = 32,
  localparam int TAGLEN   = PA_BITS - SETLEN - OFFSETLEN,
  localparam int BEATS    = LINELEN / AHBW,
  localparam int BOFF     = $clog2(AHBW / 8),
  localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MissReq,
  input  logic [PA_BITS-1:0] MissAdr,
  input  logic [NUMWAYS-1:0] VictimWay,
  input  logic               VictimDirty,
  input  logic [TAGLEN-1:0]  VictimTag,
  input  logic [LINELEN-1:0] LineRead,
  cache_evict_fill_if.master bus,
  output logic [LINELEN-1:0] FillData,
  output logic [NUMWAYS-1:0] FillWay,
  output logic               ClearValid,
  output logic               SetValid,
  output logic               LRUWriteEn,
  output logic               MissDone,
  output logic               Busy,
  output logic [1:0]         DebugState
);

  typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

  state_t                      state, stateNext;
  logic   [BW-1:0]             beatCnt, cntNext;
  logic                        accept;
  logic                        lastBeat;
  logic   [PA_BITS-OFFSETLEN-1:0] lineAdrQ;
  logic   [NUMWAYS-1:0]        wayQ;
  logic   [TAGLEN-1:0]         tagQ;
  logic   [LINELEN-1:0]        wbBuf;
  logic   [LINELEN-1:0]        fillBuf;
  logic   [BW-1:0]             startBeat;
  logic   [BW-1:0]             beatIdx;
  logic   [PA_BITS-1:0]        wbBase, fetchBase, beatOff;
  logic                        unusedOffsetBits;

  // Offset bits below the beat index never reach the bus; the line base is always beat-aligned.
  assign unusedOffsetBits = ^MissAdr[OFFSETLEN-1:0];

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic [BW-1:0] critQ;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       critQ <= '0;
    else if (accept) critQ <= MissAdr[OFFSETLEN-1:BOFF];
  end
  assign startBeat = critQ;
`else
  assign startBeat = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      state   <= stateNext;
      beatCnt <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = beatCnt;
    accept    = 1'b0;
    lastBeat  = (beatCnt == BW'(BEATS - 1));
    case (state)
      IDLE: begin
        if (MissReq) begin
          accept    = 1'b1;
          stateNext = VictimDirty ? WB : FETCH;
          cntNext   = '0;
        end
      end
      WB: begin
        if (bus.BusAck) begin
          cntNext = beatCnt + BW'(1);
          if (lastBeat) stateNext = FETCH;
        end
      end
      FETCH: begin
        if (bus.BusAck) begin
          cntNext = beatCnt + BW'(1);
          if (lastBeat) stateNext = FILL;
        end
      end
      FILL:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // beatCnt counts acks; the fetch position is offset from it so wraparound falls out of BW-bit math.
  assign beatIdx   = (state == FETCH) ? beatCnt + startBeat : beatCnt;
  assign wbBase    = {tagQ, lineAdrQ[SETLEN-1:0], {OFFSETLEN{1'b0}}};
  assign fetchBase = {lineAdrQ, {OFFSETLEN{1'b0}}};
  assign beatOff   = PA_BITS'(beatIdx) << BOFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lineAdrQ <= '0;
      wayQ     <= '0;
      tagQ     <= '0;
      wbBuf    <= '0;
      fillBuf  <= '0;
    end else begin
      if (accept) begin
        lineAdrQ <= MissAdr[PA_BITS-1:OFFSETLEN];
        wayQ     <= VictimWay;
        tagQ     <= VictimTag;
        wbBuf    <= LineRead;
      end
      if (state == FETCH && bus.BusAck) fillBuf[beatIdx*AHBW +: AHBW] <= bus.BusRData;
    end
  end

  assign bus.BusReq   = (state == WB) || (state == FETCH);
  assign bus.BusWrite = (state == WB);
  assign bus.BusAdr   = (state == WB)    ? wbBase + beatOff :
                        (state == FETCH) ? fetchBase + beatOff : '0;
  assign bus.BusWData = (state == WB) ? wbBuf[beatIdx*AHBW +: AHBW] : '0;

  assign ClearValid = (state == IDLE) && MissReq;
  assign FillWay    = ClearValid ? VictimWay : wayQ;
  assign FillData   = fillBuf;
  assign SetValid   = (state == FILL);
  assign LRUWriteEn = (state == FILL);
  assign MissDone   = (state == FILL);
  assign Busy       = (state != IDLE);
  assign DebugState = state;

  a_victim_onehot: assert property (@(posedge clk) disable iff (reset)
    ((state == IDLE) && MissReq) |-> $onehot(VictimWay));

endmodule

// File: tb/tb_cache_evict_fill.sv
// Directed plus randomized miss sequences against an address-level model of the evict/fill protocol.
module tb_cache_evict_fill;
  localparam int QW = 1 + 32 + 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         MissReq;
  logic [31:0]  MissAdr;
  logic [3:0]   VictimWay;
  logic         VictimDirty;
  logic [19:0]  VictimTag;
  logic [255:0] LineRead;
  logic [255:0] FillData;
  logic [3:0]   FillWay;
  logic         ClearValid, SetValid, LRUWriteEn, MissDone, Busy;
  logic [1:0]   DebugState;

  int checks   = 0;
  int failures = 0;
  logic [QW-1:0] exp_q[$];

  cache_evict_fill_if #(.PA_BITS(32), .AHBW(64)) bus ();

  cache_evict_fill dut (
    .clk(clk), .reset(reset), .MissReq(MissReq), .MissAdr(MissAdr), .VictimWay(VictimWay),
    .VictimDirty(VictimDirty), .VictimTag(VictimTag), .LineRead(LineRead), .bus(bus.master),
    .FillData(FillData), .FillWay(FillWay), .ClearValid(ClearValid), .SetValid(SetValid),
    .LRUWriteEn(LRUWriteEn), .MissDone(MissDone), .Busy(Busy), .DebugState(DebugState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busreq"},   bus.BusReq, 0);
    check({tag, "_buswrite"}, bus.BusWrite, 0);
    check({tag, "_busadr"},   bus.BusAdr, 0);
    check({tag, "_buswdata"}, bus.BusWData, 0);
    check({tag, "_filldata"}, FillData, 0);
    check({tag, "_fillway"},  FillWay, 0);
    check({tag, "_clrvalid"}, ClearValid, 0);
    check({tag, "_setvalid"}, SetValid, 0);
    check({tag, "_lru"},      LRUWriteEn, 0);
    check({tag, "_done"},     MissDone, 0);
    check({tag, "_busy"},     Busy, 0);
    check({tag, "_dbg"},      DebugState, 0);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  // waitMode: >=0 fixed wait cycles before every beat, <0 random waits. expLat 0 skips the absolute check.
  task automatic run_miss(input logic [31:0] adr, input logic [3:0] way, input logic dirty,
                          input logic [19:0] tag, input logic [255:0] line, input int waitMode,
                          input int expLat, input bit poke);
    logic [255:0] expFill;
    logic [QW-1:0] e;
    logic [31:0] ea;
    logic [63:0] d;
    int start, cyc, busCyc, waits;
    bit done, poked, ack;
    expFill = '0;
    exp_q.delete();
    if (dirty)
      for (int k = 0; k < 4; k++)
        exp_q.push_back({1'b1, {tag, adr[11:5], 5'b0} + 32'(k * 8), line[k*64 +: 64]});
    start = 0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    start = int'(adr[4:3]);
`endif
    for (int k = 0; k < 4; k++)
      exp_q.push_back({1'b0, {adr[31:5], 5'b0} + 32'(((start + k) % 4) * 8), 64'h0});

    @(negedge clk);
    MissReq = 1'b1; MissAdr = adr; VictimWay = way; VictimDirty = dirty; VictimTag = tag; LineRead = line;
    #1;
    check("acc_clrvalid", ClearValid, 1);
    check("acc_fillway", FillWay, way);
    check("acc_busy", Busy, 0);
    @(posedge clk);
    #1 MissReq = 1'b0;

    cyc = 0; busCyc = 0; waits = 0; done = 0; poked = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.BusAck = 1'b0;
      MissReq = 1'b0;
      if (SetValid) begin
        check("fill_data", FillData, expFill);
        check("fill_way", FillWay, way);
        check("fill_lru", LRUWriteEn, 1);
        check("fill_done", MissDone, 1);
        check("fill_busreq", bus.BusReq, 0);
        check("fill_after_last_ack", cyc, busCyc + 1);
        check("fill_beats_left", exp_q.size(), 0);
        if (expLat > 0) check("fill_latency", cyc, expLat);
        done = 1;
      end else begin
        check("busy", Busy, 1);
        check("no_clrvalid", ClearValid, 0);
        check("hold_way", FillWay, way);
        if (exp_q.size() == 0) begin
          check("extra_beat", bus.BusReq, 0);
        end else begin
          e = exp_q[0];
          ea = e[95:64];
          check("beat_req", bus.BusReq, 1);
          check("beat_write", bus.BusWrite, e[96]);
          check("beat_adr", bus.BusAdr, ea);
          if (e[96]) check("beat_wdata", bus.BusWData, e[63:0]);
          busCyc++;
          if (poke && !poked && !e[96]) begin
            MissReq = 1'b1;
            MissAdr = adr ^ 32'h0000_0100;
            VictimWay = ~way;
            poked = 1;
          end
          ack = (waitMode < 0) ? ($urandom_range(0, 2) != 0) : (waits >= waitMode);
          if (ack) begin
            waits = 0;
            bus.BusAck = 1'b1;
            if (!e[96]) begin
              d = {$urandom(), $urandom()};
              bus.BusRData = d;
              expFill[ea[4:3]*64 +: 64] = d;
            end
            void'(exp_q.pop_front());
          end else begin
            waits++;
            bus.BusRData = {$urandom(), $urandom()};
          end
        end
      end
    end
    bus.BusAck = 1'b0;
    MissReq = 1'b0;
    VictimWay = way;
    check("fill_seen", done, 1);
    @(negedge clk);
    check("post_busy", Busy, 0);
    check("post_done", MissDone, 0);
    check("post_setvalid", SetValid, 0);
  endtask

  task automatic reset_mid_wb();
    @(negedge clk);
    MissReq = 1'b1; MissAdr = 32'h0000_2080; VictimWay = 4'b0010; VictimDirty = 1'b1;
    VictimTag = 20'hABCDE; LineRead = rand_line();
    @(posedge clk);
    #1 MissReq = 1'b0;
    @(negedge clk);
    check("rst_wb0_adr", bus.BusAdr, {20'hABCDE, 7'h04, 5'h00});
    bus.BusAck = 1'b1;
    @(negedge clk);
    check("rst_wb1_write", bus.BusWrite, 1);
    check("rst_wb1_adr", bus.BusAdr, {20'hABCDE, 7'h04, 5'h08});
    bus.BusAck = 1'b0;
    reset = 1'b1;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_hold");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_after_setvalid", SetValid, 0);
      check("rst_after_busy", Busy, 0);
    end
  endtask

  initial begin
    logic [3:0] w;
    reset = 1'b1; MissReq = 1'b0; MissAdr = '0; VictimWay = 4'b0001; VictimDirty = 1'b0;
    VictimTag = '0; LineRead = '0; bus.BusAck = 1'b0; bus.BusRData = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    bus.BusAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ack_busy", Busy, 0);
      check("idle_ack_req", bus.BusReq, 0);
    end
    bus.BusAck = 1'b0;

    run_miss(32'h0000_1040, 4'b0100, 1'b0, 20'h00000, rand_line(), 0, 5, 1'b0);
    run_miss(32'h0000_1040, 4'b0100, 1'b1, 20'h12345, rand_line(), 0, 9, 1'b0);
    run_miss(32'h0000_1040, 4'b0100, 1'b0, 20'h00000, rand_line(), 3, 17, 1'b0);
    run_miss(32'h0000_1040, 4'b1000, 1'b0, 20'h00000, rand_line(), 0, 5, 1'b1);
    run_miss(32'h0000_1050, 4'b0001, 1'b0, 20'h00000, rand_line(), 0, 5, 1'b0);
    run_miss(32'h0000_1058, 4'b0010, 1'b1, 20'h0F00F, rand_line(), 1, 17, 1'b0);

    reset_mid_wb();
    run_miss(32'h0000_2080, 4'b0010, 1'b0, 20'h00000, rand_line(), 0, 5, 1'b0);

    for (int n = 0; n < 20; n++) begin
      w = 4'b0001 << $urandom_range(0, 3);
      run_miss($urandom(), w, 1'($urandom_range(0, 1)), 20'($urandom()), rand_line(), -1, 0,
               1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
